// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the CPU port, the DMA port and the data memory of dmem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the masters' and memory's view.
interface dmem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// CPU-priority arbiter for a single-port synchronous data memory shared with a DMA master.
// A starvation counter forces one DMA grant after MAX_CPU_BURST CPU grants made while DMA waits.
module dmem_bus_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_CPU_BURST = 4
) (
  input logic                clk,
  input logic                reset,
  dmem_bus_arbiter_if.slave  bus
);

  typedef enum logic {CPU_PRI, DMA_FORCE} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DMA} owner_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_CPU_BURST);

  state_t            state, state_next;
  owner_t            rd_owner, rd_owner_next;
  logic [3:0]        streak, streak_next;
  logic              cpu_granted, dma_granted;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CPU_PRI;
      streak   <= '0;
      rd_owner <= RD_NONE;
    end else begin
      state    <= state_next;
      streak   <= streak_next;
      rd_owner <= rd_owner_next;
    end
  end

  // Grants are held off entirely while reset is low so nothing reaches the memory.
  always_comb begin
    cpu_granted = 1'b0;
    dma_granted = 1'b0;
    if (reset) begin
      case (state)
        CPU_PRI: begin
          cpu_granted = bus.cpu_req;
          dma_granted = !bus.cpu_req && bus.dma_req;
        end
        DMA_FORCE: begin
          dma_granted = bus.dma_req;
          cpu_granted = !bus.dma_req && bus.cpu_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    streak_next = '0;
    if (cpu_granted && bus.dma_req)
      streak_next = (streak == MAX_CNT) ? streak : streak + 4'd1;

    state_next = state;
    case (state)
      CPU_PRI:   if (streak_next == MAX_CNT) state_next = DMA_FORCE;
      DMA_FORCE: if (dma_granted || !bus.dma_req) state_next = CPU_PRI;
      default:   state_next = CPU_PRI;
    endcase

    rd_owner_next = RD_NONE;
    if (cpu_granted && !bus.cpu_we)
      rd_owner_next = RD_CPU;
    else if (dma_granted && !bus.dma_we)
      rd_owner_next = RD_DMA;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    if (cpu_granted) begin
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end else if (dma_granted) begin
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  // Read data is steered by the registered owner, so only the issuing master ever sees it.
  always_comb begin
    bus.mem_en     = cpu_granted || dma_granted;
    bus.mem_we     = (cpu_granted && bus.cpu_we) || (dma_granted && bus.dma_we);
    bus.mem_addr   = sel_addr;
    bus.mem_wdata  = sel_wdata;
    bus.cpu_stall  = reset && bus.cpu_req && !cpu_granted;
    bus.dma_gnt    = dma_granted;
    bus.cpu_rdata  = (rd_owner == RD_CPU) ? bus.mem_rdata : '0;
    bus.dma_rdata  = (rd_owner == RD_DMA) ? bus.mem_rdata : '0;
    bus.dma_rvalid = (rd_owner == RD_DMA);
  end

endmodule
